// File: rtl/video_ram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter slice.
//   - cpu_state_e : CPU transaction FSM states
//   - rd_owner_e  : who owns the RAM read data returning next cycle
//   - VRAM geometry constants
package video_ram_arbiter_pkg;

  localparam int VRAM_ADDR_W        = 11;
  localparam int VRAM_BYTES_PER_ROW = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } cpu_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/video_ram_arbiter_sat.sv
// WIDTH-bit saturating increment counter with asynchronous active-low clear.
// Ports:
//   clk    : clock
//   resetN : asynchronous active-low clear
//   inc    : increment request for this cycle
//   count  : current value, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/video_ram_arbiter.sv
// Arbitrates the single-port video RAM between the beam-driven video fetch
// and the CPU bus.
//
// Video fetch owns every slot cycle (visible && x[2:0]==0); CPU accesses are
// fitted into the remaining cycles.
//
// CPU handshake: cpuReq is a level held with cpuWe/cpuAddr/cpuWdata stable
// until cpuAck. An access is granted in IDLE on the first cycle with no video
// slot (and, with CPU_BLANK_ONLY, only while visible==0); cpuAck pulses for
// one cycle two cycles after the grant, with cpuRdata valid for reads. The
// requester drops cpuReq, or presents a new request, at the edge ending ACK.
//
// Ports:
//   clk, resetN              : clock, asynchronous active-low reset
//   x, visible, vidAddr      : beam position, active area flag, video address
//   vidData, vidValid        : registered video byte and its one-cycle strobe
//   cpuReq/We/Addr/Wdata     : CPU request side
//   cpuRdata, cpuAck         : CPU response side
//   ramEn/We/Addr/Wdata      : RAM command (combinational)
//   ramRdata                 : RAM read data, valid the cycle after ramEn
//   conflictCount            : saturating count of CPU grants deferred by video
//   dbgState                 : current CPU FSM state
module video_ram_arbiter
  import video_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = VRAM_ADDR_W,
  parameter bit CPU_BLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [8:0]        x,
  input  logic              visible,
  input  logic [ADDR_W-1:0] vidAddr,
  output logic [7:0]        vidData,
  output logic              vidValid,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [7:0]        cpuWdata,
  output logic [7:0]        cpuRdata,
  output logic              cpuAck,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [7:0]        ramWdata,
  input  logic [7:0]        ramRdata,
  output logic [7:0]        conflictCount,
  output logic [1:0]        dbgState
);

  cpu_state_e state;
  rd_owner_e  rd_owner;
  logic       cpu_we_q;
  logic       slot;
  logic       cpu_ok;
  logic       cpu_grant;
  logic       conflict;
  logic       unused_x;

  // Only the low three x bits define the fetch slot.
  assign unused_x  = ^x[8:3];

  assign slot      = visible && (x[2:0] == 3'd0);
  assign cpu_ok    = !CPU_BLANK_ONLY || !visible;
  assign cpu_grant = resetN && !slot && (state == IDLE) && cpu_ok && cpuReq;
  assign conflict  = (state == IDLE) && cpuReq && cpu_ok && slot;
  assign dbgState  = state;

  // RAM command mux; held quiet during reset so every output reads 0.
  always_comb begin
    ramEn    = 1'b0;
    ramWe    = 1'b0;
    ramAddr  = '0;
    ramWdata = '0;
    if (resetN) begin
      if (slot) begin
        ramEn   = 1'b1;
        ramAddr = vidAddr;
      end else if (cpu_grant) begin
        ramEn    = 1'b1;
        ramWe    = cpuWe;
        ramAddr  = cpuAddr;
        ramWdata = cpuWdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      rd_owner <= OWN_NONE;
      cpu_we_q <= 1'b0;
      cpuRdata <= '0;
      cpuAck   <= 1'b0;
      vidData  <= '0;
      vidValid <= 1'b0;
    end else begin
      cpuAck   <= 1'b0;
      vidValid <= 1'b0;

      // Tag who issued this cycle's access so next cycle's ramRdata is steered.
      if (slot)           rd_owner <= OWN_VID;
      else if (cpu_grant) rd_owner <= OWN_CPU;
      else                rd_owner <= OWN_NONE;

      if (rd_owner == OWN_VID) begin
        vidData  <= ramRdata;
        vidValid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cpu_grant) begin
            state    <= DATA;
            cpu_we_q <= cpuWe;
          end
        end
        DATA: begin
          // Write keeps the previous read value on cpuRdata.
          if ((rd_owner == OWN_CPU) && !cpu_we_q) cpuRdata <= ramRdata;
          cpuAck <= 1'b1;
          state  <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(8)) u_conflict_cnt (
    .clk    (clk),
    .resetN (resetN),
    .inc    (conflict),
    .count  (conflictCount)
  );

endmodule

// File: tb/tb_video_ram_arbiter.sv
module tb_video_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetN;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared beam inputs ----------------
  logic [8:0]  x;
  logic        visible;
  logic [10:0] vidAddr;

  // ---------------- DUT A (CPU_BLANK_ONLY=0) ----------------
  logic [7:0]  vidData, cpuWdata, cpuRdata, ramWdata, ramRdata, conflictCount;
  logic        vidValid, cpuReq, cpuWe, cpuAck, ramEn, ramWe;
  logic [10:0] cpuAddr, ramAddr;
  logic [1:0]  dbgState;

  // ---------------- DUT B (CPU_BLANK_ONLY=1) ----------------
  logic [7:0]  vidData_b, cpuWdata_b, cpuRdata_b, ramWdata_b, ramRdata_b, conflictCount_b;
  logic        vidValid_b, cpuReq_b, cpuWe_b, cpuAck_b, ramEn_b, ramWe_b;
  logic [10:0] cpuAddr_b, ramAddr_b;
  logic [1:0]  dbgState_b;

  video_ram_arbiter #(.ADDR_W(11), .CPU_BLANK_ONLY(1'b0)) dut (
    .clk(clk), .resetN(resetN), .x(x), .visible(visible), .vidAddr(vidAddr),
    .vidData(vidData), .vidValid(vidValid), .cpuReq(cpuReq), .cpuWe(cpuWe),
    .cpuAddr(cpuAddr), .cpuWdata(cpuWdata), .cpuRdata(cpuRdata), .cpuAck(cpuAck),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWdata(ramWdata),
    .ramRdata(ramRdata), .conflictCount(conflictCount), .dbgState(dbgState)
  );

  video_ram_arbiter #(.ADDR_W(11), .CPU_BLANK_ONLY(1'b1)) dut_b (
    .clk(clk), .resetN(resetN), .x(x), .visible(visible), .vidAddr(vidAddr),
    .vidData(vidData_b), .vidValid(vidValid_b), .cpuReq(cpuReq_b), .cpuWe(cpuWe_b),
    .cpuAddr(cpuAddr_b), .cpuWdata(cpuWdata_b), .cpuRdata(cpuRdata_b), .cpuAck(cpuAck_b),
    .ramEn(ramEn_b), .ramWe(ramWe_b), .ramAddr(ramAddr_b), .ramWdata(ramWdata_b),
    .ramRdata(ramRdata_b), .conflictCount(conflictCount_b), .dbgState(dbgState_b)
  );

  // ---------------- RAM arrays (synchronous, read-first) ----------------
  logic [7:0] mem_a [2048];
  logic [7:0] mem_b [2048];
  always @(posedge clk) if (ramEn) begin
    if (ramWe) mem_a[ramAddr] <= ramWdata;
    ramRdata <= mem_a[ramAddr];
  end
  always @(posedge clk) if (ramEn_b) begin
    if (ramWe_b) mem_b[ramAddr_b] <= ramWdata_b;
    ramRdata_b <= mem_b[ramAddr_b];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  model [2048];     // what the memory should hold
  logic [7:0]  last_rd;          // what cpuRdata should show
  int          exp_conf;         // expected conflict count
  logic [7:0]  b_exp;
  logic [39:0] exp_vid_q[$];     // {cycle, data}
  logic [39:0] exp_cpu_q[$];     // {cycle, rdata}
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- beam driver: applies inputs on negedge ----------------
  bit          vis_ctrl = 1'b0;
  bit          x_load   = 1'b0;
  logic [8:0]  x_load_val = '0;
  logic [10:0] vid_ptr = '0;

  initial begin
    x = '0; visible = 1'b0; vidAddr = '0;
    forever begin
      @(negedge clk);
      if (x_load) begin x = x_load_val; x_load = 1'b0; end
      else x = x + 9'd1;
      visible = vis_ctrl;
      vidAddr = vid_ptr;
      if (resetN && visible && (x[2:0] == 3'd0)) begin
        exp_vid_q.push_back({32'(cyc + 2), model[vidAddr]});
        vid_ptr = vid_ptr + 11'd1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk); #1;
      if (resetN && vidValid) begin
        if (exp_vid_q.size() == 0) fail_now("vid_unexpected");
        else begin
          e = exp_vid_q.pop_front();
          check("vid_cycle", cyc, e[39:8]);
          check("vid_data", {24'd0, vidData}, {24'd0, e[7:0]});
        end
      end
      if (resetN && cpuAck) begin
        if (exp_cpu_q.size() == 0) fail_now("ack_unexpected");
        else begin
          e = exp_cpu_q.pop_front();
          check("ack_cycle", cyc, e[39:8]);
          check("ack_rdata", {24'd0, cpuRdata}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // ---------------- CPU driver task (DUT A) ----------------
  task automatic cpu_access(input logic we, input logic [10:0] addr, input logic [7:0] wd,
                            input bit align, input int budget);
    int         waited;
    int         guard;
    bit         granted;
    logic [7:0] expd;
    waited = 0; granted = 1'b0; guard = 0;
    @(negedge clk); #2;
    if (align) begin
      while (!(visible && x[2:0] == 3'd0) && guard < 20) begin
        @(negedge clk); #2; guard++;
      end
    end
    cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wd;
    #1;
    while (!granted && waited <= budget) begin
      if (!(visible && x[2:0] == 3'd0)) begin
        granted = 1'b1;
        check("grant_cmd", {19'd0, ramEn, ramWe, ramAddr}, {19'd0, 1'b1, we, addr});
        if (we) check("grant_wdata", {24'd0, ramWdata}, {24'd0, wd});
        if (we) begin expd = last_rd; model[addr] = wd; end
        else begin expd = model[addr]; last_rd = expd; end
        exp_cpu_q.push_back({32'(cyc + 2), expd});
      end else begin
        exp_conf = (exp_conf >= 255) ? 255 : exp_conf + 1;
        check("defer_cmd", {19'd0, ramEn, ramWe, ramAddr}, {19'd0, 1'b1, 1'b0, vidAddr});
        waited++;
        @(negedge clk); #3;
      end
    end
    if (!granted) begin
      fail_now("grant_timeout");
      @(negedge clk); cpuReq = 1'b0;
    end else begin
      // DATA: scramble request fields; the in-flight access must not change.
      @(negedge clk); #3;
      cpuAddr = 11'($urandom); cpuWe = 1'($urandom); cpuWdata = 8'($urandom); #1;
      check("data_no_we", {31'd0, ramWe}, 32'd0);
      @(negedge clk); #3;
      check("ack_no_we", {31'd0, ramWe}, 32'd0);
      @(negedge clk);
      cpuReq = 1'b0; cpuWe = 1'b0;
      #3 check("conflict_count", {24'd0, conflictCount}, 32'(exp_conf));
    end
  endtask

  task automatic do_reset_assert();
    resetN = 1'b0;
    exp_vid_q.delete();
    exp_cpu_q.delete();
    last_rd  = '0;
    exp_conf = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    int acks;
    logic [7:0] v;
    for (int i = 0; i < 2048; i++) begin
      v = 8'($urandom);
      mem_a[i] = v; mem_b[i] = v; model[i] = v;
    end
    b_exp = mem_b[11'h050];
    cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
    cpuReq_b = 0; cpuWe_b = 0; cpuAddr_b = 0; cpuWdata_b = 0;
    do_reset_assert();

    // 1. reset: outputs quiet while cpuReq toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); cpuReq = i[0]; cpuAddr = 11'($urandom); cpuWe = 1'($urandom); #3;
      check("rst_out_a", {7'd0, vidData, vidValid, cpuRdata, cpuAck, conflictCount},
            32'd0);
      check("rst_out_b", {10'd0, ramEn, ramWe, ramAddr, ramWdata, dbgState}, 32'd0);
    end
    @(negedge clk); cpuReq = 0; #2 resetN = 1'b1;

    // 2. write then read back, blanking
    cpu_access(1'b1, 11'h123, 8'hA5, 1'b0, 0);
    cpu_access(1'b0, 11'h123, 8'h00, 1'b0, 0);
    cpu_access(1'b1, 11'h000, 8'h10, 1'b0, 0);
    cpu_access(1'b1, 11'h001, 8'h38, 1'b0, 0);
    check("model_a5", {24'd0, model[11'h123]}, 32'h0000_00A5);

    // 3. video fetch sweep from x=0
    x_load_val = 9'd0; x_load = 1'b1; vid_ptr = 11'h000; vis_ctrl = 1'b1;
    repeat (18) @(negedge clk);

    // 4. collision: request raised on a slot cycle
    cpu_access(1'b0, 11'h050, 8'h00, 1'b1, 1);
    check("collision_count", {24'd0, conflictCount}, 32'd1);

    // random mix of accesses across visible and blank
    for (int i = 0; i < 40; i++) begin
      vis_ctrl = 1'($urandom);
      cpu_access(1'($urandom), 11'($urandom_range(0, 15)), 8'($urandom),
                 vis_ctrl && ($urandom_range(0, 1) == 1), 1);
    end

    // 5. blank-only instance: no grant while visible
    vis_ctrl = 1'b1;
    @(negedge clk); #2;
    cpuReq_b = 1'b1; cpuWe_b = 1'b0; cpuAddr_b = 11'h050;
    bad = 0;
    repeat (100) begin
      @(negedge clk); #3;
      if (ramWe_b || cpuAck_b || (ramEn_b != (visible && x[2:0] == 3'd0))) bad++;
    end
    check("blank_no_grant", bad, 0);
    vis_ctrl = 1'b0;
    @(negedge clk); #3;
    check("blank_grant", {19'd0, ramEn_b, ramWe_b, ramAddr_b}, {19'd0, 1'b1, 1'b0, 11'h050});
    @(negedge clk); #3;
    check("blank_data_noack", {31'd0, cpuAck_b}, 32'd0);
    @(negedge clk); #3;
    check("blank_ack", {31'd0, cpuAck_b}, 32'd1);
    check("blank_rdata", {24'd0, cpuRdata_b}, {24'd0, b_exp});
    check("blank_conf", {24'd0, conflictCount_b}, 32'd0);
    @(negedge clk); cpuReq_b = 1'b0;

    // 6a. saturation
    vis_ctrl = 1'b1;
    repeat (300) cpu_access(1'($urandom), 11'($urandom_range(0, 31)), 8'($urandom), 1'b1, 1);
    check("sat_255", {24'd0, conflictCount}, 32'd255);

    // 6b. reset during DATA
    vis_ctrl = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk); #2;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 11'h077;
    #1 check("rst_grant", {20'd0, ramEn, ramAddr}, {20'd0, 1'b1, 11'h077});
    @(negedge clk); #2;
    check("rst_in_data", {30'd0, dbgState}, 32'd1);
    do_reset_assert();
    cpuReq = 1'b0;
    #1 check("rst_state_idle", {30'd0, dbgState}, 32'd0);
    acks = 0;
    repeat (3) begin @(negedge clk); #3; if (cpuAck) acks++; end
    resetN = 1'b1;
    repeat (4) begin @(negedge clk); #3; if (cpuAck) acks++; end
    check("rst_no_ack", acks, 0);
    check("rst_conf_zero", {24'd0, conflictCount}, 32'd0);
    check("rst_rdata_zero", {24'd0, cpuRdata}, 32'd0);

    // re-request after reset completes normally
    cpu_access(1'b0, 11'h123, 8'h00, 1'b0, 0);
    repeat (6) @(negedge clk);
    check("cpu_q_empty", exp_cpu_q.size(), 0);
    check("vid_q_empty", exp_vid_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_ram_arbiter.md
Name: video_ram_arbiter

Overview:
- Shares the single-port 2K x 8 video RAM between the beam-driven video fetch and the Z8 CPU bus.
- The video fetch has absolute priority and a fixed slot: visible && x[2:0]==0. CPU reads and writes go through a req/ack handshake and are fitted into the free cycles.
- Sits between the CPU bus decoder, the video address generator and the RAM array. It also counts deferred CPU accesses for debug.

Parameters:
- ADDR_W, 11, RAM address width (2048 bytes).
- CPU_BLANK_ONLY, 0, when 1 the CPU is granted only while visible==0.

Ports:
- clk  in  1  system clock, 8 MHz
- resetN  in  1  asynchronous active-low reset
- x  in  9  beam x position
- visible  in  1  beam inside the active area
- vidAddr  in  ADDR_W  address of the next video byte
- vidData  out  8  fetched video byte, registered
- vidValid  out  1  one-cycle pulse: vidData is new
- cpuReq  in  1  CPU access request, level, held until cpuAck
- cpuWe  in  1  1=write, 0=read; stable while cpuReq is high
- cpuAddr  in  ADDR_W  CPU address; stable while cpuReq is high
- cpuWdata  in  8  write data
- cpuRdata  out  8  read data, registered; valid while cpuAck is high
- cpuAck  out  1  one-cycle completion pulse
- ramEn  out  1  RAM access strobe
- ramWe  out  1  RAM write enable
- ramAddr  out  ADDR_W  RAM address
- ramWdata  out  8  RAM write data
- ramRdata  in  8  RAM read data, synchronous, valid the cycle after ramEn
- conflictCount  out  8  saturating count of CPU grants deferred by a video slot

Behaviour:
- The clock port is clk; reset is the asynchronous, active-low resetN.
- On reset:
  - state=IDLE.
  - All outputs are 0: vidData, vidValid, cpuRdata, cpuAck, conflictCount, and the RAM ports.
  - In-flight reads are discarded and no ack is issued.
- Slot signal: slot = visible && x[2:0]==0, combinational.
- RAM port mux, combinational:
  - When slot is high: ramEn=1, ramWe=0, ramAddr=vidAddr. The video fetch wins in every state.
  - Otherwise, in IDLE when cpuOk && cpuReq: ramEn=1, ramWe=cpuWe, ramAddr=cpuAddr, ramWdata=cpuWdata. This cycle is the CPU grant.
  - Otherwise ramEn=0 and ramWe=0.
- cpuOk = !CPU_BLANK_ONLY || !visible.
- Read-owner tag register rdOwner (NONE, VID, CPU) records who drove ramEn in the previous cycle. It steers ramRdata in the following cycle.
- CPU FSM:
  - IDLE -> DATA on a CPU grant.
  - DATA: if rdOwner==CPU and the access was a read, cpuRdata <= ramRdata; cpuAck <= 1; next state is ACK.
  - ACK: cpuAck is high for exactly this cycle; next state is IDLE.
  - At the edge ending ACK the requester must drop cpuReq or present a new request. A new request is granted in IDLE at the earliest 3 cycles after the previous grant.
- Writes use the same latency as reads. cpuRdata keeps its previous value on a write.
- Video pipeline:
  - Slot in cycle S.
  - vidData <= ramRdata at the end of S+1.
  - vidValid=1 during S+2 only.
  - Video slots in the DATA or ACK cycles are serviced without disturbing the CPU transaction.
- Conflict counting: a cycle in IDLE with cpuReq && cpuOk && slot defers the CPU. That cycle increments conflictCount, which saturates at 255 and never wraps.
- Waiting: while visible, the maximum wait for a grant is 1 cycle. With CPU_BLANK_ONLY=1, the CPU waits until visible falls. A request pending when visible falls is granted on the first non-slot IDLE cycle.
- Changes to cpuReq, cpuAddr or cpuWe during DATA or ACK have no effect. The transaction already in flight completes.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately. The pending ack is lost and the CPU must re-request.

Decomposition:
- Shared package holds:
  - the CPU FSM state encoding (IDLE, DATA, ACK);
  - the rdOwner encoding (NONE, VID, CPU);
  - VRAM_ADDR_W=11 and VRAM_BYTES_PER_ROW=40.
- One natural sub-module, sat_counter: WIDTH-bit saturating increment counter with async active-low clear. It is used for conflictCount.
- Everything else stays in this module.

Test Plan:
1. Reset: hold resetN=0, then release; toggle cpuReq with visible=0 -> all outputs 0 while reset; first grant occurs on the cycle after release.
2. CPU write then read, visible=0: write 0xA5 to address 0x123, then read 0x123 -> ramWe high for exactly one cycle; cpuAck pulses 2 cycles after each grant; cpuRdata=0xA5 during the read ack.
3. Video fetch: visible=1, x sweeps 0..15, vidAddr=0x000 then 0x001, RAM preloaded with 0x10 at 0x000 and 0x38 at 0x001 -> vidValid pulses at x=2 and x=10; vidData=0x10 then 0x38.
4. Collision: visible=1 and cpuReq read 0x050 raised on a cycle with x=8 -> video is granted at x=8 and the CPU at x=9; conflictCount=1; ack at x=11; video data is unaffected.
5. Blank-only mode: CPU_BLANK_ONLY=1, cpuReq held while visible=1 for 100 cycles -> no CPU grant; grant on the first non-slot cycle after visible falls; conflictCount stays 0.
6. Saturation and reset mid-operation:
   - Force 300 collisions -> conflictCount=255.
   - Assert resetN=0 during DATA -> cpuAck never pulses; conflictCount=0 after reset.
